user_rq_rc_mux: RTL and testbench

Parametrised multi-channel requester front end for the PCIe root-port user logic. It merges `NUM_CH` independent encoder AXI-S requester request (RQ) streams onto the single core-facing RQ interface. Arbitration is round-robin and packet-atomic, and each packet's tag is stamped with the channel index. Requester completions (RC) are routed back to the originating channel by tag. The block sits between the per-channel TLP encoder/decoder pairs and the ISQ/ICQ buffers, so several controllers can share one link.

---
 rtl/user_rq_rc_mux.sv | 231 +++++++++++++++++++++++
 tb/tb_user_rq_rc_mux.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_rq_rc_mux.sv
// user_rq_rc_mux: merges NUM_CH requester-request (RQ) AXI-S streams onto one
// core-facing RQ port and routes requester completions (RC) back by tag.
//   - RQ: packet-atomic round-robin arbiter. The channel index is stamped into
//     the descriptor tag MSBs on the first beat of each packet.
//   - RC: 1-cycle registered router keyed on the completion tag MSBs. Packets
//     whose tag addresses a channel that does not exist are dropped.
// Optional feature: define USER_RQ_RC_MUX_STATS_EN to build the saturating
// packet counters. When it is undefined, the stat ports are tied to 0.
module user_rq_rc_mux #(
    parameter int NUM_CH              = 2,
    parameter int CH_BITS             = $clog2(NUM_CH),
    parameter int C_DATA_WIDTH        = 128,
    parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32,
    parameter int AXI4_RQ_TUSER_WIDTH = 62,
    parameter int AXI4_RC_TUSER_WIDTH = 75
) (
    input  logic                                  user_clk,
    input  logic                                  reset,
    // per-channel RQ sources, ch0 in the LSBs
    input  logic [NUM_CH*C_DATA_WIDTH-1:0]        ch_rq_tdata,
    input  logic [NUM_CH*KEEP_WIDTH-1:0]          ch_rq_tkeep,
    input  logic [NUM_CH*AXI4_RQ_TUSER_WIDTH-1:0] ch_rq_tuser,
    input  logic [NUM_CH-1:0]                     ch_rq_tlast,
    input  logic [NUM_CH-1:0]                     ch_rq_tvalid,
    output logic [NUM_CH-1:0]                     ch_rq_tready,
    // core-facing RQ
    output logic [C_DATA_WIDTH-1:0]               s_axis_rq_tdata,
    output logic [KEEP_WIDTH-1:0]                 s_axis_rq_tkeep,
    output logic [AXI4_RQ_TUSER_WIDTH-1:0]        s_axis_rq_tuser,
    output logic                                  s_axis_rq_tlast,
    output logic                                  s_axis_rq_tvalid,
    input  logic                                  s_axis_rq_tready,
    // core-facing RC (no backpressure)
    input  logic [C_DATA_WIDTH-1:0]               m_axis_rc_tdata,
    input  logic [KEEP_WIDTH-1:0]                 m_axis_rc_tkeep,
    input  logic [AXI4_RC_TUSER_WIDTH-1:0]        m_axis_rc_tuser,
    input  logic                                  m_axis_rc_tlast,
    input  logic                                  m_axis_rc_tvalid,
    // per-channel RC outputs
    output logic [NUM_CH*C_DATA_WIDTH-1:0]        ch_rc_tdata,
    output logic [NUM_CH*KEEP_WIDTH-1:0]          ch_rc_tkeep,
    output logic [NUM_CH*AXI4_RC_TUSER_WIDTH-1:0] ch_rc_tuser,
    output logic [NUM_CH-1:0]                     ch_rc_tlast,
    output logic [NUM_CH-1:0]                     ch_rc_tvalid,
    output logic                                  rc_drop,
    // statistics
    output logic [NUM_CH*16-1:0]                  stat_rq_pkts,
    output logic [NUM_CH*16-1:0]                  stat_rc_pkts,
    output logic [15:0]                           stat_drops
);

    typedef enum logic {IDLE, FWD} rq_state_e;

    // Per-channel views of the flat RQ buses
    logic [NUM_CH-1:0][C_DATA_WIDTH-1:0]        rq_data_a;
    logic [NUM_CH-1:0][KEEP_WIDTH-1:0]          rq_keep_a;
    logic [NUM_CH-1:0][AXI4_RQ_TUSER_WIDTH-1:0] rq_user_a;

    assign rq_data_a = ch_rq_tdata;
    assign rq_keep_a = ch_rq_tkeep;
    assign rq_user_a = ch_rq_tuser;

    rq_state_e          state_q, state_d;
    logic [CH_BITS-1:0] grant_q, grant_d;
    logic [CH_BITS-1:0] last_q, last_d;
    logic               rq_first_q, rq_first_d;

    // First requester scanning upward from last+1, wrapping at NUM_CH
    function automatic logic [CH_BITS-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                   input logic [CH_BITS-1:0] last);
        logic [CH_BITS-1:0] pick;
        logic [CH_BITS-1:0] cand;
        logic               found;
        int                 idx;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = int'(last) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            cand = CH_BITS'(idx);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // RQ arbiter next state and combinational pass-through of the granted channel
    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        last_d           = last_q;
        rq_first_d       = rq_first_q;
        ch_rq_tready     = '0;
        s_axis_rq_tdata  = '0;
        s_axis_rq_tkeep  = '0;
        s_axis_rq_tuser  = '0;
        s_axis_rq_tlast  = 1'b0;
        s_axis_rq_tvalid = 1'b0;
        case (state_q)
            IDLE: begin
                if (|ch_rq_tvalid) begin
                    grant_d    = rr_pick(ch_rq_tvalid, last_q);
                    rq_first_d = 1'b1;
                    state_d    = FWD;
                end
            end
            FWD: begin
                s_axis_rq_tvalid = ch_rq_tvalid[grant_q];
                s_axis_rq_tdata  = rq_data_a[grant_q];
                s_axis_rq_tkeep  = rq_keep_a[grant_q];
                s_axis_rq_tuser  = rq_user_a[grant_q];
                s_axis_rq_tlast  = ch_rq_tlast[grant_q];
                // Tag MSBs carry the channel so completions can find their way home
                if (rq_first_q) s_axis_rq_tdata[103 -: CH_BITS] = grant_q;
                ch_rq_tready[grant_q] = s_axis_rq_tready;
                if (ch_rq_tvalid[grant_q] && s_axis_rq_tready) begin
                    rq_first_d = 1'b0;
                    if (ch_rq_tlast[grant_q]) begin
                        last_d  = grant_q;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // RQ arbiter state; reset parks last on NUM_CH-1 so ch0 wins first
    always_ff @(posedge user_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            last_q     <= CH_BITS'(NUM_CH - 1);
            rq_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            rq_first_q <= rq_first_d;
        end
    end

    // RC routing: channel comes from the tag on the first beat, then is held
    logic                           rc_first_q;
    logic [CH_BITS-1:0]             rc_ch_q;
    logic [CH_BITS-1:0]             rc_sel;
    logic                           rc_hit;
    logic [C_DATA_WIDTH-1:0]        rc_data_q;
    logic [KEEP_WIDTH-1:0]          rc_keep_q;
    logic [AXI4_RC_TUSER_WIDTH-1:0] rc_user_q;
    logic                           rc_last_q;
    logic [NUM_CH-1:0]              rc_vld_q;
    logic                           rc_drop_q;

    assign rc_sel = rc_first_q ? m_axis_rc_tdata[71 -: CH_BITS] : rc_ch_q;
    // Only reachable as a miss when NUM_CH is not a power of two
    assign rc_hit = int'(rc_sel) < NUM_CH;

    // RC output register: one beat of latency, valid only on the routed channel
    always_ff @(posedge user_clk) begin
        if (reset) begin
            rc_first_q <= 1'b1;
            rc_ch_q    <= '0;
            rc_data_q  <= '0;
            rc_keep_q  <= '0;
            rc_user_q  <= '0;
            rc_last_q  <= 1'b0;
            rc_vld_q   <= '0;
            rc_drop_q  <= 1'b0;
        end else begin
            rc_vld_q  <= '0;
            rc_drop_q <= 1'b0;
            if (m_axis_rc_tvalid) begin
                rc_data_q  <= m_axis_rc_tdata;
                rc_keep_q  <= m_axis_rc_tkeep;
                rc_user_q  <= m_axis_rc_tuser;
                rc_last_q  <= m_axis_rc_tlast;
                rc_first_q <= m_axis_rc_tlast;
                if (rc_first_q) rc_ch_q <= m_axis_rc_tdata[71 -: CH_BITS];
                if (rc_hit) rc_vld_q[rc_sel] <= 1'b1;
                else        rc_drop_q        <= m_axis_rc_tlast;
            end
        end
    end

    // Payload is shared by all channels; only tvalid selects the recipient
    assign ch_rc_tdata  = {NUM_CH{rc_data_q}};
    assign ch_rc_tkeep  = {NUM_CH{rc_keep_q}};
    assign ch_rc_tuser  = {NUM_CH{rc_user_q}};
    assign ch_rc_tlast  = {NUM_CH{rc_last_q}};
    assign ch_rc_tvalid = rc_vld_q;
    assign rc_drop      = rc_drop_q;

`ifdef USER_RQ_RC_MUX_STATS_EN
    logic [NUM_CH-1:0][15:0] rq_cnt_q;
    logic [NUM_CH-1:0][15:0] rc_cnt_q;
    logic [15:0]             drop_cnt_q;

    // Saturating packet counters, bumped on each tlast handshake
    always_ff @(posedge user_clk) begin
        if (reset) begin
            rq_cnt_q   <= '0;
            rc_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (s_axis_rq_tvalid && s_axis_rq_tready && s_axis_rq_tlast &&
                rq_cnt_q[grant_q] != 16'hFFFF)
                rq_cnt_q[grant_q] <= rq_cnt_q[grant_q] + 16'd1;
            if (m_axis_rc_tvalid && m_axis_rc_tlast) begin
                if (rc_hit) begin
                    if (rc_cnt_q[rc_sel] != 16'hFFFF)
                        rc_cnt_q[rc_sel] <= rc_cnt_q[rc_sel] + 16'd1;
                end else if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_q <= drop_cnt_q + 16'd1;
                end
            end
        end
    end

    assign stat_rq_pkts = rq_cnt_q;
    assign stat_rc_pkts = rc_cnt_q;
    assign stat_drops   = drop_cnt_q;
`else
    assign stat_rq_pkts = '0;
    assign stat_rc_pkts = '0;
    assign stat_drops   = '0;
`endif

endmodule

// File: tb/tb_user_rq_rc_mux.sv
// Directed bench for user_rq_rc_mux: a 4-channel instance for arbitration,
// tag stamping, backpressure, RC routing and mid-packet reset, plus a
// 3-channel instance for the out-of-range completion drop.
module tb_user_rq_rc_mux;

    localparam int DW = 128, KW = 4, RQU = 62, RCU = 75, N = 4, N3 = 3;
`ifdef USER_RQ_RC_MUX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic user_clk = 1'b0;
    logic reset    = 1'b1;
    always #5 user_clk = ~user_clk;

    // 4-channel instance
    logic [N*DW-1:0]  ch_rq_tdata;
    logic [N*KW-1:0]  ch_rq_tkeep;
    logic [N*RQU-1:0] ch_rq_tuser;
    logic [N-1:0]     ch_rq_tlast, ch_rq_tvalid, ch_rq_tready;
    logic [DW-1:0]    s_tdata;
    logic [KW-1:0]    s_tkeep;
    logic [RQU-1:0]   s_tuser;
    logic             s_tlast, s_tvalid;
    logic             s_tready = 1'b1;
    logic [DW-1:0]    rc_tdata = '0;
    logic [KW-1:0]    rc_tkeep = '0;
    logic [RCU-1:0]   rc_tuser = '0;
    logic             rc_tlast = 1'b0, rc_tvalid = 1'b0;
    logic [N*DW-1:0]  o_rc_tdata;
    logic [N*KW-1:0]  o_rc_tkeep;
    logic [N*RCU-1:0] o_rc_tuser;
    logic [N-1:0]     o_rc_tlast, o_rc_tvalid;
    logic             rc_drop;
    logic [N*16-1:0]  stat_rq, stat_rc;
    logic [15:0]      stat_drops;

    // 3-channel instance (RC path only exercised)
    logic [DW-1:0]     rc3_tdata = '0;
    logic              rc3_tlast = 1'b0, rc3_tvalid = 1'b0;
    logic [N3-1:0]     z_rq_tready;
    logic [DW-1:0]     z_s_tdata;
    logic [KW-1:0]     z_s_tkeep;
    logic [RQU-1:0]    z_s_tuser;
    logic              z_s_tlast, z_s_tvalid;
    logic [N3*DW-1:0]  o3_rc_tdata;
    logic [N3*KW-1:0]  o3_rc_tkeep;
    logic [N3*RCU-1:0] o3_rc_tuser;
    logic [N3-1:0]     o3_rc_tlast, o3_rc_tvalid;
    logic              rc_drop3;
    logic [N3*16-1:0]  stat_rq3, stat_rc3;
    logic [15:0]       stat_drops3;

    user_rq_rc_mux #(.NUM_CH(N)) u4 (
        .user_clk(user_clk), .reset(reset),
        .ch_rq_tdata(ch_rq_tdata), .ch_rq_tkeep(ch_rq_tkeep), .ch_rq_tuser(ch_rq_tuser),
        .ch_rq_tlast(ch_rq_tlast), .ch_rq_tvalid(ch_rq_tvalid), .ch_rq_tready(ch_rq_tready),
        .s_axis_rq_tdata(s_tdata), .s_axis_rq_tkeep(s_tkeep), .s_axis_rq_tuser(s_tuser),
        .s_axis_rq_tlast(s_tlast), .s_axis_rq_tvalid(s_tvalid), .s_axis_rq_tready(s_tready),
        .m_axis_rc_tdata(rc_tdata), .m_axis_rc_tkeep(rc_tkeep), .m_axis_rc_tuser(rc_tuser),
        .m_axis_rc_tlast(rc_tlast), .m_axis_rc_tvalid(rc_tvalid),
        .ch_rc_tdata(o_rc_tdata), .ch_rc_tkeep(o_rc_tkeep), .ch_rc_tuser(o_rc_tuser),
        .ch_rc_tlast(o_rc_tlast), .ch_rc_tvalid(o_rc_tvalid), .rc_drop(rc_drop),
        .stat_rq_pkts(stat_rq), .stat_rc_pkts(stat_rc), .stat_drops(stat_drops)
    );

    user_rq_rc_mux #(.NUM_CH(N3)) u3 (
        .user_clk(user_clk), .reset(reset),
        .ch_rq_tdata('0), .ch_rq_tkeep('0), .ch_rq_tuser('0),
        .ch_rq_tlast('0), .ch_rq_tvalid('0), .ch_rq_tready(z_rq_tready),
        .s_axis_rq_tdata(z_s_tdata), .s_axis_rq_tkeep(z_s_tkeep), .s_axis_rq_tuser(z_s_tuser),
        .s_axis_rq_tlast(z_s_tlast), .s_axis_rq_tvalid(z_s_tvalid), .s_axis_rq_tready(1'b1),
        .m_axis_rc_tdata(rc3_tdata), .m_axis_rc_tkeep(4'hF), .m_axis_rc_tuser('0),
        .m_axis_rc_tlast(rc3_tlast), .m_axis_rc_tvalid(rc3_tvalid),
        .ch_rc_tdata(o3_rc_tdata), .ch_rc_tkeep(o3_rc_tkeep), .ch_rc_tuser(o3_rc_tuser),
        .ch_rc_tlast(o3_rc_tlast), .ch_rc_tvalid(o3_rc_tvalid), .rc_drop(rc_drop3),
        .stat_rq_pkts(stat_rq3), .stat_rc_pkts(stat_rc3), .stat_drops(stat_drops3)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // RQ beat payload: id byte = {ch, beat}, tag field, channel marker in MSB byte
    function automatic logic [DW-1:0] mk(input int c, input int b, input logic [7:0] tag);
        logic [DW-1:0] d;
        d           = '0;
        d[7:0]      = 8'(c * 16 + b);
        d[103:96]   = tag;
        d[127:120]  = 8'(160 + c);
        return d;
    endfunction

    function automatic logic [DW-1:0] rcb(input logic [7:0] tag, input logic [15:0] id);
        logic [DW-1:0] d;
        d         = '0;
        d[71:64]  = tag;
        d[15:0]   = id;
        return d;
    endfunction

    // Per-channel RQ source model
    int         nb[N], bc[N];
    bit         act[N], rep[N];
    logic [7:0] tg[N];

    task automatic drive_rq();
        for (int c = 0; c < N; c++) begin
            ch_rq_tvalid[c]            = act[c];
            ch_rq_tdata[c*DW +: DW]    = mk(c, bc[c], tg[c]);
            ch_rq_tkeep[c*KW +: KW]    = 4'hF;
            ch_rq_tuser[c*RQU +: RQU]  = RQU'(c * 256 + bc[c]);
            ch_rq_tlast[c]             = (bc[c] == nb[c] - 1);
        end
        #2;
    endtask

    // Advance sources on handshake, then move to 1 time unit after the next edge
    task automatic fin();
        for (int c = 0; c < N; c++) begin
            if (act[c] && ch_rq_tready[c]) begin
                if (bc[c] == nb[c] - 1) begin
                    bc[c]  = 0;
                    act[c] = rep[c];
                end else begin
                    bc[c]++;
                end
            end
        end
        @(posedge user_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int c = 0; c < N; c++) begin
            act[c] = 0; bc[c] = 0; nb[c] = 1; rep[c] = 0; tg[c] = 8'h00;
        end
        rc_tvalid = 1'b0; rc_tlast = 1'b0; rc3_tvalid = 1'b0; rc3_tlast = 1'b0;
        s_tready  = 1'b1;
        drive_rq();
        @(posedge user_clk); #1;
        @(posedge user_clk); #1;
        chk("rst_s_tvalid", s_tvalid, 0);
        chk("rst_s_tdata", s_tdata, 0);
        chk("rst_rq_ready", ch_rq_tready, 0);
        chk("rst_rc_tvalid", o_rc_tvalid, 0);
        chk("rst_rc_tdata", o_rc_tdata[127:0], 0);
        chk("rst_rc_drop", {rc_drop, rc_drop3}, 0);
        chk("rst_stats", {stat_rq, stat_rc, stat_drops}, 0);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] exp;
        int g, b;

        // ---------------- round-robin fairness ----------------
        do_reset();
        for (int c = 0; c < N; c++) begin
            nb[c] = 2; act[c] = 1; rep[c] = 1; tg[c] = 8'h05;
        end
        for (int k = 0; k < 15; k++) begin
            drive_rq();
            g = (k / 3) % 4;
            b = (k % 3) - 1;
            if (k % 3 == 0) begin
                chk($sformatf("rr_bubble_vld%0d", k), s_tvalid, 0);
                chk($sformatf("rr_bubble_rdy%0d", k), ch_rq_tready, 0);
            end else begin
                exp = mk(g, b, 8'h05);
                if (b == 0) exp[103:102] = g[1:0];
                chk($sformatf("rr_vld%0d", k), s_tvalid, 1);
                chk($sformatf("rr_data%0d", k), s_tdata, exp);
                chk($sformatf("rr_last%0d", k), s_tlast, (b == 1));
                chk($sformatf("rr_rdy%0d", k), ch_rq_tready, 4'b0001 << g);
            end
            fin();
        end
        chk("stat_rq", stat_rq, STATS ? 64'h0001_0001_0001_0002 : 64'h0);

        // ---------------- tag stamping ----------------
        do_reset();
        act[2] = 1; tg[2] = 8'h15;
        drive_rq(); chk("tag_idle_rdy", ch_rq_tready, 0); fin();
        drive_rq();
        chk("tag_ch2", s_tdata[103:96], 8'h95);
        chk("tag_ch2_low", s_tdata[7:0], 8'h20);
        chk("tag_ch2_user", s_tuser, 512);
        chk("tag_ch2_rdy", ch_rq_tready, 4'b0100);
        fin();
        act[0] = 1; tg[0] = 8'hD5;
        drive_rq(); chk("tag_bubble", s_tvalid, 0); fin();
        drive_rq();
        chk("tag_ch0", s_tdata[103:96], 8'h15);
        chk("tag_ch0_rdy", ch_rq_tready, 4'b0001);
        fin();

        // ---------------- backpressure ----------------
        do_reset();
        nb[1] = 4; act[1] = 1; tg[1] = 8'h33;
        act[3] = 1; tg[3] = 8'h07;
        drive_rq(); fin();
        drive_rq();
        chk("bp_b0", s_tdata, mk(1, 0, 8'h73));
        chk("bp_b0_rdy", ch_rq_tready, 4'b0010);
        fin();
        s_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_rq();
            chk($sformatf("bp_hold_vld%0d", k), s_tvalid, 1);
            chk($sformatf("bp_hold_data%0d", k), s_tdata, mk(1, 1, 8'h33));
            chk($sformatf("bp_hold_rdy%0d", k), ch_rq_tready, 0);
            fin();
        end
        s_tready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            drive_rq();
            chk($sformatf("bp_resume_data%0d", k), s_tdata, mk(1, k, 8'h33));
            chk($sformatf("bp_resume_last%0d", k), s_tlast, (k == 3));
            chk($sformatf("bp_resume_rdy%0d", k), ch_rq_tready, 4'b0010);
            fin();
        end
        drive_rq(); chk("bp_bubble", s_tvalid, 0); fin();
        drive_rq();
        chk("bp_next_rdy", ch_rq_tready, 4'b1000);
        chk("bp_next_data", s_tdata, mk(3, 0, 8'hC7));
        fin();

        // ---------------- RC routing ----------------
        do_reset();
        rc_tvalid = 1; rc_tlast = 0; rc_tdata = rcb(8'h4A, 16'hD000);
        rc_tkeep = 4'h7; rc_tuser = 75'h123;
        drive_rq(); fin();
        rc_tdata = rcb(8'hFF, 16'hD001); rc_tkeep = 4'hF;
        drive_rq();
        chk("rc_b0_vld", o_rc_tvalid, 4'b0010);
        chk("rc_b0_data", o_rc_tdata[1*DW +: DW], rcb(8'h4A, 16'hD000));
        chk("rc_b0_keep", o_rc_tkeep[1*KW +: KW], 4'h7);
        chk("rc_b0_user", o_rc_tuser[1*RCU +: RCU], 75'h123);
        fin();
        rc_tvalid = 0;
        drive_rq();
        chk("rc_b1_vld", o_rc_tvalid, 4'b0010);
        chk("rc_b1_data", o_rc_tdata[1*DW +: DW], rcb(8'hFF, 16'hD001));
        fin();
        rc_tvalid = 1; rc_tlast = 1; rc_tdata = rcb(8'h00, 16'hD002);
        drive_rq();
        chk("rc_gap_vld", o_rc_tvalid, 0);
        fin();
        rc_tvalid = 0; rc_tlast = 0;
        drive_rq();
        chk("rc_b2_vld", o_rc_tvalid, 4'b0010);
        chk("rc_b2_last", o_rc_tlast[1], 1);
        chk("rc_b2_data", o_rc_tdata[1*DW +: DW], rcb(8'h00, 16'hD002));
        chk("rc_no_drop", rc_drop, 0);
        fin();
        drive_rq();
        chk("rc_idle_vld", o_rc_tvalid, 0);
        chk("stat_rc", stat_rc, STATS ? 64'h0000_0000_0001_0000 : 64'h0);
        fin();

        // ---------------- drop (3 channels) ----------------
        do_reset();
        rc3_tvalid = 1; rc3_tlast = 0; rc3_tdata = rcb(8'hC0, 16'hE000);
        drive_rq(); fin();
        rc3_tlast = 1; rc3_tdata = rcb(8'h00, 16'hE001);
        drive_rq();
        chk("drop_b0_vld", o3_rc_tvalid, 0);
        chk("drop_b0_pulse", rc_drop3, 0);
        fin();
        rc3_tlast = 1; rc3_tdata = rcb(8'h80, 16'hE100);
        drive_rq();
        chk("drop_b1_vld", o3_rc_tvalid, 0);
        chk("drop_pulse", rc_drop3, 1);
        fin();
        rc3_tvalid = 0; rc3_tlast = 0;
        drive_rq();
        chk("drop_pulse_end", rc_drop3, 0);
        chk("drop_next_vld", o3_rc_tvalid, 3'b100);
        chk("stat_drops", stat_drops3, STATS ? 16'd1 : 16'd0);
        fin();

        // ---------------- mid-packet reset ----------------
        do_reset();
        nb[1] = 4; act[1] = 1; tg[1] = 8'h00;
        drive_rq(); fin();
        drive_rq(); chk("mr_b0_rdy", ch_rq_tready, 4'b0010); fin();
        reset = 1'b1;
        rc_tvalid = 1; rc_tlast = 0; rc_tdata = rcb(8'hC0, 16'hF000);
        drive_rq();
        chk("mr_b1_rdy", ch_rq_tready, 4'b0010);
        fin();
        reset = 1'b0;
        for (int c = 0; c < N; c++) begin
            bc[c] = 0; nb[c] = 1; rep[c] = 0; act[c] = (c < 2);
        end
        rc_tvalid = 1; rc_tlast = 1; rc_tdata = rcb(8'h40, 16'hF001);
        drive_rq();
        chk("mr_s_tvalid", s_tvalid, 0);
        chk("mr_rdy", ch_rq_tready, 0);
        chk("mr_rc_vld", o_rc_tvalid, 0);
        fin();
        rc_tvalid = 0; rc_tlast = 0;
        drive_rq();
        chk("mr_first_grant", ch_rq_tready, 4'b0001);
        chk("mr_first_vld", s_tvalid, 1);
        chk("mr_rc_first", o_rc_tvalid, 4'b0010);
        fin();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
